bcd_to_binary_seq: RTL and testbench
====================================

# bcd_to_binary_seq

Sequential BCD-to-binary converter: accepts a packed multi-digit BCD value (hundreds/tens/ones by default) and produces its binary equivalent by reverse double-dabble, one shift-adjust step per clock. It is the inverse of the display-side binary-to-BCD path. It sits between the keypad/digit-entry logic and the stack computer's operand push port, so that user-entered decimal operands become 8-bit stack words.

## Interface
Parameters:
- `WIDTH`, 8: binary result width; also the number of shift-adjust iterations.
- `DIGITS`, 3: number of BCD digits on the input.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: conversion request; sampled only in IDLE.
- `bcd`, input, 4*DIGITS: packed digits, most significant digit in the top nibble.
- `busy`, output, 1: high while a conversion is in progress.
- `valid`, output, 1: one-cycle pulse when `number` and `err` are updated.
- `number`, output, WIDTH: converted binary value; held between conversions.
- `err`, output, 1: range/format error for the latest result; exists only with the macro below.

## Operation
- FSM states: IDLE and SHIFT.
- **IDLE, start=1:**
  - Load the working register {digits, WIDTH zero bits} with `bcd`.
  - Clear the iteration counter.
  - Set `busy`=1 and go to SHIFT.
- **IDLE, start=0:** hold.
- **SHIFT, per iteration:**
  - Logical-shift the whole register right by 1.
  - Then, for each 4-bit digit field, if the value is ≥8, subtract 3.
  - Increment the counter.
- **Last iteration (counter = WIDTH-1):** the post-step value is used directly.
  - `number` ← low WIDTH bits.
  - `valid` ← 1 for one cycle.
  - `busy` ← 0.
  - State ← IDLE.
- After WIDTH iterations, the residual digit fields hold the value shifted right by WIDTH, still in BCD. Non-zero residual digits mean the input exceeds 2^WIDTH-1.
- `start` while `busy` is high is ignored. It is neither queued nor able to disturb the running conversion.
- `bcd` is sampled only in the load cycle; later changes to it are ignored.
- **Reset (any time, including mid-conversion):**
  - State = IDLE, counter = 0.
  - `busy`=0, `valid`=0, `number`=0, `err`=0.
  - An aborted conversion produces no `valid`.

## Timing
- `start` sampled high at edge k (in IDLE): `busy` is high from edge k.
- Final result lands at edge k+WIDTH: `number`, `err` and `valid`=1 update together and `busy` falls. Latency is WIDTH cycles (8 by default).
- `valid` is low again after edge k+WIDTH+1 unless another conversion completes on that edge.
- `start` high during the `valid` cycle (state is IDLE) is accepted at edge k+WIDTH+1. Back-to-back throughput is one result per WIDTH+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
Macro: `BCD2BIN_RANGE_CHECK_EN`.

When defined:
- At load, any input digit >9 sets a sticky internal flag.
- At completion, `err` = flag OR (residual digits ≠ 0).
- If `err`=1, `number` is forced to 0. Otherwise `err`=0 and `number` is the result.

When undefined:
- No checking logic is built.
- The `err` port is still present, tied to 0.
- `number` is always the low WIDTH bits. Out-of-range or invalid inputs give undefined but deterministic values.

## Structure
- Package `bcd2bin_pkg` holds:
  - the FSM state enum (IDLE, SHIFT);
  - constants `BCD_DIGIT_MAX`=9, `BCD_ADJ_THRESH`=8, `BCD_ADJ_VALUE`=3;
  - the counter width function, clog2 of WIDTH.
- Sub-module `bcd_digit_adjust`: purely combinational, one 4-bit digit in, one out, subtracting 3 when the digit is ≥8. Instantiated DIGITS times on the shifted register.

## Test plan
- bcd=0x255, start pulse: `busy` for 8 cycles, then `valid` pulse with `number`=0xFF, `err`=0.
- bcd=0x000 and bcd=0x128: `number`=0x00 and 0x80 respectively, each exactly 8 cycles after `start`.
- With macro, bcd=0x256: `err`=1, `number`=0. bcd=0x1A3 (digit >9): `err`=1. Without macro, 0x256 gives `err`=0 and `number`=0x00.
- `start` held high continuously with bcd=0x042: `valid` pulses every 9 cycles with `number`=0x2A. Changing `bcd` mid-conversion does not alter the result.
- `rst_n` asserted 4 cycles into a conversion: all outputs go to 0 immediately. No `valid` appears, and the next `start` converts normally.

Source files
------------

// File: rtl/bcd2bin_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   state_t    : converter FSM states (IDLE, SHIFT)
//   BCD_*      : digit limit and reverse double-dabble adjust constants
//   cnt_width  : width of the iteration counter for a given result width
package bcd2bin_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] BCD_ADJ_VALUE  = 4'd3;

    // clog2 of the iteration count, never narrower than one bit
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational per-digit correction for reverse double-dabble.
//   din  : 4-bit digit field after the right shift
//   dout : din - 3 when din >= 8, otherwise din
module bcd_digit_adjust
    import bcd2bin_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= BCD_ADJ_THRESH) ? (din - BCD_ADJ_VALUE) : din;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one
// shift-adjust step per clock, WIDTH steps per conversion).
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : conversion request, sampled only while idle
//   bcd        : packed BCD digits, most significant digit in the top nibble
//   busy       : conversion in progress
//   valid      : one-cycle pulse when number/err update
//   number     : binary result, held between conversions
//   err        : range/format error of the latest result
// Optional macro BCD2BIN_RANGE_CHECK_EN enables digit and range checking;
// without it err is tied low and number is the raw low WIDTH bits.
module bcd_to_binary_seq
    import bcd2bin_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  valid,
    output logic [WIDTH-1:0]      number,
    output logic                  err
);

    localparam int RW = 4*DIGITS + WIDTH;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state_q, state_d;
    logic [RW-1:0]   work_q;
    logic [RW-1:0]   shifted;
    logic [RW-1:0]   stepped;
    logic [CW-1:0]   cnt_q;
    logic            load;
    logic            done;
    logic [WIDTH-1:0] res_num;

    // One iteration: shift right, then correct every digit field.
    // Bits shifted into the low WIDTH positions form the binary result.
    assign shifted               = work_q >> 1;
    assign stepped[WIDTH-1:0]    = shifted[WIDTH-1:0];

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (shifted[WIDTH + 4*i +: 4]),
            .dout (stepped[WIDTH + 4*i +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            cnt_q  <= '0;
            valid  <= 1'b0;
            number <= '0;
        end else begin
            valid <= 1'b0;
            if (load) begin
                work_q <= {bcd, {WIDTH{1'b0}}};
                cnt_q  <= '0;
            end else if (state_q == SHIFT) begin
                work_q <= stepped;
                cnt_q  <= cnt_q + 1'b1;
            end
            // the final step's value is taken straight from the adjust network
            if (done) begin
                valid  <= 1'b1;
                number <= res_num;
            end
        end
    end

`ifdef BCD2BIN_RANGE_CHECK_EN
    logic bad_in;
    logic bad_q;
    logic res_err;

    always_comb begin
        bad_in = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > BCD_DIGIT_MAX) bad_in = 1'b1;
        end
    end

    // residual digits hold value >> WIDTH; any non-zero digit is overflow
    assign res_err = bad_q | (|stepped[RW-1:WIDTH]);
    assign res_num = res_err ? '0 : stepped[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_q <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (load) bad_q <= bad_in;
            if (done) err   <= res_err;
        end
    end
`else
    assign res_num = stepped[WIDTH-1:0];
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed cases, back-to-back
// throughput, mid-conversion reset and randomized conversions against a
// decimal-arithmetic reference model.
module tb_bcd_to_binary_seq;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [4*DIGITS-1:0] bcd;
    logic                busy;
    logic                valid;
    logic [WIDTH-1:0]    number;
    logic                err;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_to_binary_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bcd    (bcd),
        .busy   (busy),
        .valid  (valid),
        .number (number),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: interpret digits as a decimal number, then apply range rules.
    task automatic model(input logic [11:0] b, output int unsigned num, output bit e);
        int unsigned v;
        bit bad;
        v   = b[11:8] * 100 + b[7:4] * 10 + b[3:0];
        bad = (b[11:8] > 9) || (b[7:4] > 9) || (b[3:0] > 9);
`ifdef BCD2BIN_RANGE_CHECK_EN
        e   = bad || (v > 255);
        num = e ? 0 : v;
`else
        e   = 1'b0;
        num = v % 256;
`endif
    endtask

    // One conversion with exact latency checking; optionally disturbs bcd
    // and pulses start while busy.
    task automatic convert(input logic [11:0] val, input bit disturb, input string tag);
        int unsigned exp_num;
        bit          exp_err;
        model(val, exp_num, exp_err);
        @(negedge clk);
        bcd   = val;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        for (int c = 1; c < WIDTH; c++) begin
            if (disturb && c == 3) begin
                bcd   = 12'($urandom);
                start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            check({tag, "_valid_early"}, valid, 0);
        end
        @(posedge clk); #1;
        check({tag, "_valid"}, valid, 1);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_number"}, number, exp_num);
        check({tag, "_err"}, err, exp_err);
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, valid, 0);
    endtask

    function automatic logic [11:0] rand_bcd(input bit allow_bad);
        logic [11:0] r;
        r = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        if (allow_bad && $urandom_range(0, 3) == 0)
            r[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bcd   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_number", number, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        convert(12'h255, 1'b0, "max");
        convert(12'h000, 1'b0, "zero");
        convert(12'h128, 1'b0, "d128");
        convert(12'h256, 1'b0, "over");
`ifdef BCD2BIN_RANGE_CHECK_EN
        convert(12'h1A3, 1'b0, "baddig");
`endif
        convert(12'h199, 1'b1, "disturb");

        // start held high: a result every WIDTH+1 cycles, bcd wobble ignored
        @(negedge clk);
        bcd   = 12'h042;
        start = 1'b1;
        @(posedge clk); #1;
        for (int e = 1; e <= 3 * (WIDTH + 1) - 1; e++) begin
            @(posedge clk); #1;
            if (e % (WIDTH + 1) == 4) bcd = 12'h987;
            if (e % (WIDTH + 1) == 7) bcd = 12'h042;
            check("b2b_valid", valid, (e % (WIDTH + 1) == WIDTH) ? 1 : 0);
            check("b2b_busy", busy, (e % (WIDTH + 1) == WIDTH) ? 0 : 1);
            if (e % (WIDTH + 1) == WIDTH) begin
                check("b2b_number", number, 'h2A);
                check("b2b_err", err, 0);
            end
        end
        start = 1'b0;

        // reset four cycles into a conversion
        @(negedge clk);
        bcd   = 12'h200;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        check("abort_number", number, 0);
        check("abort_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            check("abort_no_valid", valid, 0);
        end
        convert(12'h173, 1'b0, "after_abort");

`ifdef BCD2BIN_RANGE_CHECK_EN
        for (int n = 0; n < 40; n++) convert(rand_bcd(1'b1), n[0], "rand");
`else
        for (int n = 0; n < 40; n++) convert(rand_bcd(1'b0), n[0], "rand");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
